mt_rn_arbiter: RTL

Controller and round-robin distributor for one `mt_fsm` Mersenne Twister generator.
- Sequences seeding: the power-up seed, plus run-time reseeds on request.
- Buffers the generator's non-stallable `valid_rn` stream in a small FIFO.
- Hands each 32-bit word to exactly one of NUM_REQ consumers.
- Sits between `mt_fsm` and the statistics/consumer logic; the generator is never stalled.

---
 rtl/mt_pkg.sv | 13 +
 rtl/mt_rn_fifo.sv | 54 +++++
 rtl/mt_rn_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/mt_pkg.sv
// Shared types and constants for the Mersenne Twister round-robin arbiter.
package mt_pkg;

  localparam int unsigned MT_WORD_W = 32;
  localparam logic [MT_WORD_W-1:0] SEED_DEFAULT = 32'hFEEDBEEF;

  typedef enum logic [1:0] {
    SEED = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } mt_arb_state_t;

endpackage

// File: rtl/mt_rn_fifo.sv
// Synchronous FIFO with flush; the head word reads as zero when the FIFO is empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module mt_rn_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array: written on accepted pushes, never reset.
  always_ff @(posedge clk) begin
    if (w_do_push && rst && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy tracking; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/mt_rn_arbiter.sv
// Seeding controller and round-robin distributor for one mt_fsm generator.
// Optional drop counter output enabled by defining MT_ARB_DROP_CNT_EN.
module mt_rn_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned SEED_HOLD    = 4,
  parameter logic [31:0] SEED_DEFAULT = mt_pkg::SEED_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         gen_seed_en,
  output logic [mt_pkg::MT_WORD_W-1:0] gen_seed_value,
  input  logic [mt_pkg::MT_WORD_W-1:0] gen_rn,
  input  logic                         gen_valid,
  input  logic                         reseed_req,
  input  logic [mt_pkg::MT_WORD_W-1:0] reseed_value,
  input  logic [NUM_REQ-1:0]           cons_req,
  output logic [mt_pkg::MT_WORD_W-1:0] rn_data,
  output logic [NUM_REQ-1:0]           rn_grant,
  output logic                         busy,
  output logic                         overflow
`ifdef MT_ARB_DROP_CNT_EN
  ,output logic [mt_pkg::MT_WORD_W-1:0] drop_count
`endif
);

  import mt_pkg::*;

  localparam int unsigned PTR_W = (NUM_REQ > 1)   ? $clog2(NUM_REQ)   : 1;
  localparam int unsigned CNT_W = (SEED_HOLD > 1) ? $clog2(SEED_HOLD) : 1;

  mt_arb_state_t          r_state;
  mt_arb_state_t          w_next_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_next_cnt;
  logic                   r_seed_en;
  logic                   r_busy;
  logic                   r_ovf;
  logic [MT_WORD_W-1:0]   r_seed_val;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_cand;
  logic [PTR_W-1:0]       w_gnt_idx;
  logic                   w_found;
  logic [NUM_REQ-1:0]     w_grant;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_full;
  logic                   w_empty;
  logic [MT_WORD_W-1:0]   w_head;
`ifdef MT_ARB_DROP_CNT_EN
  logic [MT_WORD_W-1:0]   r_drop_cnt;
`endif

  mt_rn_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (MT_WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (gen_rn),
    .i_pop   (w_found),
    .i_flush (reseed_req),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_cand    = '0;
    w_found   = 1'b0;
    if (rst && !reseed_req && (r_state == RUN) && !w_empty) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_cand = PTR_W'((32'(r_ptr) + k) % NUM_REQ);
        if (!w_found && cons_req[w_cand]) begin
          w_found   = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end
    if (w_found) w_grant = NUM_REQ'(1) << w_gnt_idx;
  end

  // Words are accepted outside SEED; a full FIFO only accepts when popping.
  assign w_push = rst && !reseed_req && (r_state != SEED) && gen_valid && (!w_full || w_found);
  assign w_drop = rst && !reseed_req && (r_state != SEED) && gen_valid && w_full && !w_found;

  // Next-state logic: hold seed for SEED_HOLD cycles, wait for first word, then run.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      SEED: begin
        if (r_cnt == CNT_W'(SEED_HOLD - 1)) begin
          w_next_state = WAIT;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + CNT_W'(1);
        end
      end
      WAIT:    if (gen_valid) w_next_state = RUN;
      RUN:     w_next_state = RUN;
      default: w_next_state = SEED;
    endcase
    if (reseed_req) begin
      w_next_state = SEED;
      w_next_cnt   = '0;
    end
  end

  // State register with registered seed-enable and busy decodes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= SEED;
      r_cnt     <= '0;
      r_seed_en <= 1'b1;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_seed_en <= (w_next_state == SEED);
      r_busy    <= (w_next_state != RUN);
    end
  end

  // Seed value, round-robin pointer and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seed_val <= SEED_DEFAULT;
      r_ptr      <= '0;
      r_ovf      <= 1'b0;
    end else if (reseed_req) begin
      r_seed_val <= reseed_value;
      r_ovf      <= 1'b0;
    end else begin
      if (w_found) r_ptr <= PTR_W'((32'(w_gnt_idx) + 32'd1) % NUM_REQ);
      if (w_drop)  r_ovf <= 1'b1;
    end
  end

`ifdef MT_ARB_DROP_CNT_EN
  // Saturating count of words dropped on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst || reseed_req) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + MT_WORD_W'(1);
    end
  end
  assign drop_count = r_drop_cnt;
`endif

  assign gen_seed_en    = r_seed_en;
  assign gen_seed_value = r_seed_val;
  assign busy           = r_busy;
  assign overflow       = r_ovf;
  assign rn_data        = w_head;
  assign rn_grant       = w_grant;

endmodule
